// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 definitions for the message scheduler:
//   WORD_W / NWORDS / ROUNDS - word width, block size in words, rounds per block
//   word_t                   - one 32-bit SHA-256 word
//   state_e                  - scheduler control states
//   K                        - the 64 SHA-256 round constants
// -----------------------------------------------------------------------------
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int NWORDS = 16;
    localparam int ROUNDS = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_e;

    localparam word_t K [0:ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_small_sigma.sv
// -----------------------------------------------------------------------------
// sha256_small_sigma
// Combinational SHA-256 small sigma function.
//   SEL = 0 : y = ROTR7(x)  ^ ROTR18(x) ^ SHR3(x)    (sigma0)
//   SEL = 1 : y = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)   (sigma1)
// Ports:
//   x  in  32  operand word
//   y  out 32  sigma result
// -----------------------------------------------------------------------------
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int SEL = 0
) (
    input  logic [31:0] x,
    output logic [31:0] y
);

    // Rotations and shifts are pure wiring: written as concatenations.
    if (SEL == 0) begin : g_sigma0
        assign y = {x[6:0],  x[31:7]}
                 ^ {x[17:0], x[31:18]}
                 ^ {3'b000,  x[31:3]};
    end else begin : g_sigma1
        assign y = {x[16:0], x[31:17]}
                 ^ {x[18:0], x[31:19]}
                 ^ {10'd0,   x[31:10]};
    end

endmodule

// File: rtl/sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// sha256_msg_sched
// SHA-256 message schedule generator. Accepts the 16 big-endian words of one
// 512-bit block on a valid/ready input stream and emits W[0..63], one word per
// handshake, on a valid/ready output stream. A 16-word sliding window holds
// W[t..t+15]; each output handshake shifts it down and appends W[t+16].
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   clr      in   1  synchronous abort back to IDLE (beats any handshake)
//   s_valid  in   1  input word valid
//   s_ready  out  1  input word accepted (IDLE / LOAD)
//   s_data   in  32  message word, M[0] first
//   m_valid  out  1  W[t] valid (EMIT)
//   m_ready  in   1  consumer accepts W[t]
//   m_data   out 32  W[t]
//   m_round  out  6  t
//   m_last   out  1  high while t == 63 is presented
//   m_wk     out 32  W[t] + K[t]  (only with SHA256_SCHED_WK_EN)
//   busy     out  1  block in progress (LOAD after first word, EMIT)
//
// Build option: define SHA256_SCHED_WK_EN to add the registered m_wk output.
// -----------------------------------------------------------------------------
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [5:0]  m_round,
    output logic        m_last,
`ifdef SHA256_SCHED_WK_EN
    output logic [31:0] m_wk,
`endif
    output logic        busy
);

    // The sigma taps and window widths below assume 32-bit words.
    if (WORD_W != 32) begin : g_word_w_check
        $error("sha256_msg_sched: WORD_W must be 32");
    end

    localparam logic [3:0] LAST_LOAD  = 4'(NWORDS - 1);
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e     state_q, state_d;
    word_t      win_q [NWORDS];
    word_t      win_d [NWORDS];
    logic [3:0] count_q, count_d;
    logic [5:0] t_q, t_d;
    logic       s_ready_q, s_ready_d;

    logic       s_fire;
    logic       m_fire;
    word_t      sig0;
    word_t      sig1;
    word_t      w_next;

    // -------------------------------------------------------------------------
    // Next schedule word: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
    // -------------------------------------------------------------------------
    sha256_small_sigma #(.SEL(0)) u_sigma0 (
        .x (win_q[1]),
        .y (sig0)
    );

    sha256_small_sigma #(.SEL(1)) u_sigma1 (
        .x (win_q[14]),
        .y (sig1)
    );

    assign w_next = sig1 + win_q[9] + sig0 + win_q[0];

    assign s_fire = s_valid && s_ready_q;
    assign m_fire = (state_q == EMIT) && m_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        count_d = count_q;
        t_d     = t_q;

        unique case (state_q)
            IDLE: begin
                if (s_fire) begin
                    win_d[0] = s_data;
                    count_d  = 4'd1;
                    state_d  = LOAD;
                end
            end

            LOAD: begin
                if (s_fire) begin
                    win_d[count_q] = s_data;
                    count_d        = count_q + 4'd1;
                    if (count_q == LAST_LOAD) begin
                        count_d = 4'd0;
                        t_d     = 6'd0;
                        state_d = EMIT;
                    end
                end
            end

            EMIT: begin
                if (m_fire) begin
                    for (int i = 0; i < NWORDS - 1; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    // Words appended for t >= 48 are never presented.
                    win_d[NWORDS - 1] = w_next;
                    t_d               = t_q + 6'd1;
                    if (t_q == LAST_ROUND) begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Abort wins over any handshake in the same cycle; the window is left
        // as computed since its contents are irrelevant after an abort.
        if (clr) begin
            state_d = IDLE;
            count_d = 4'd0;
            t_d     = 6'd0;
        end
    end

    // s_ready is a flop so that it reads 0 during reset and rises one cycle
    // after release; it is high whenever the next state can take input.
    assign s_ready_d = (state_d != EMIT);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state updates use non-blocking assignments so all flops sample
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            t_q       <= 6'd0;
            s_ready_q <= 1'b0;
            // NOTE: the window is reset because win[0] drives m_data, whose
            // reset value must be 0; storage not visible at an output would
            // normally be left unreset.
            for (int i = 0; i < NWORDS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            t_q       <= t_d;
            s_ready_q <= s_ready_d;
            win_q     <= win_d;
        end
    end

`ifdef SHA256_SCHED_WK_EN
    // W[t] + K[t] is precomputed from the next window head and next t so the
    // registered m_wk lines up with m_data on every cycle.
    word_t wk_q, wk_d;

    always_comb begin
        wk_d = win_d[0] + K[t_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wk_q <= '0;
        end else begin
            wk_q <= wk_d;
        end
    end

    assign m_wk = wk_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign s_ready = s_ready_q;
    assign m_valid = (state_q == EMIT);
    assign m_data  = win_q[0];
    assign m_round = t_q;
    assign m_last  = (state_q == EMIT) && (t_q == LAST_ROUND);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_sched
// Directed self-checking bench for sha256_msg_sched. Expected schedule words
// come from a hand-entered table of known "abc" values and from an
// independent array-based reference of the SHA-256 expansion.
// -----------------------------------------------------------------------------
module tb_sha256_msg_sched;
    import sha256_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [5:0]  m_round;
    logic        m_last;
    logic        busy;
`ifdef SHA256_SCHED_WK_EN
    logic [31:0] m_wk;
`endif

    sha256_msg_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_round (m_round),
        .m_last  (m_last),
`ifdef SHA256_SCHED_WK_EN
        .m_wk    (m_wk),
`endif
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          round;
        logic [31:0] w;
    } vec_t;

    vec_t        known [8];
    logic [31:0] abc   [16];
    logic [31:0] ramp  [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];
    logic [5:0]  got_r [64];
    logic        got_l [64];
    logic [31:0] got_wk[64];
    int          nbeats;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference expansion over a flat 64-entry array.
    task automatic build_model(input logic [31:0] blk[16]);
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = blk[t];
            end else begin
                s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
                s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
                exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            end
        end
    endtask

    // Present n_words of blk, with gap idle cycles after each accept.
    task automatic send_block(input logic [31:0] blk[16], input int n_words, input int gap);
        bit ok;
        m_ready = 1'b0;
        for (int i = 0; i < n_words; i++) begin
            s_valid = 1'b1;
            s_data  = blk[i];
            ok = 1'b0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge clk);
                if (s_ready) ok = 1'b1;
                @(posedge clk); #1;
            end
            if (!ok) timeout($sformatf("accept_w%0d", i));
            s_valid = 1'b0;
            s_data  = 32'h0;
            if (i < 15) begin
                check($sformatf("load_busy_w%0d", i), 32'(busy), 32'd1);
                check($sformatf("load_mvalid_w%0d", i), 32'(m_valid), 32'd0);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    check($sformatf("gap_sready_w%0d_%0d", i, g), 32'(s_ready), 32'd1);
                end
            end else begin
                check("first_mvalid", 32'(m_valid), 32'd1);
                check("first_sready", 32'(s_ready), 32'd0);
                check("first_round", 32'(m_round), 32'd0);
                check("first_data", m_data, blk[0]);
            end
        end
    endtask

    // Consume 64 beats; optionally random back-pressure and junk input.
    task automatic collect(input bit rnd, input bit junk);
        logic [31:0] hd;
        logic [5:0]  hr;
        bit          st;
        nbeats = 0;
        st     = 1'b0;
        hd     = '0;
        hr     = '0;
        for (int c = 0; c < 2000 && nbeats < 64; c++) begin
            m_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (junk) begin
                s_valid = 1'b1;
                s_data  = 32'hDEADBEEF;
            end
            @(negedge clk);
            if (st) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", m_data, hd);
                check("hold_round", 32'(m_round), 32'(hr));
            end
            if (m_valid) begin
                if (m_ready) begin
                    got_w[nbeats] = m_data;
                    got_r[nbeats] = m_round;
                    got_l[nbeats] = m_last;
`ifdef SHA256_SCHED_WK_EN
                    got_wk[nbeats] = m_wk;
`else
                    got_wk[nbeats] = 32'h0;
`endif
                    nbeats++;
                    st = 1'b0;
                end else begin
                    st = 1'b1;
                    hd = m_data;
                    hr = m_round;
                end
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'h0;
        if (nbeats != 64) timeout("collect_64_beats");
        check("post_mvalid", 32'(m_valid), 32'd0);
        check("post_sready", 32'(s_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    task automatic verify(input string tag, input bit use_known);
        for (int k = 0; k < nbeats; k++) begin
            check($sformatf("%s_w%0d", tag, k), got_w[k], exp_w[k]);
            check($sformatf("%s_round%0d", tag, k), 32'(got_r[k]), 32'(k));
            check($sformatf("%s_last%0d", tag, k), 32'(got_l[k]), (k == 63) ? 32'd1 : 32'd0);
`ifdef SHA256_SCHED_WK_EN
            check($sformatf("%s_wk%0d", tag, k), got_wk[k], exp_w[k] + K[k]);
`endif
        end
        if (use_known) begin
            for (int v = 0; v < 8; v++) begin
                check($sformatf("%s_known_w%0d", tag, known[v].round),
                      got_w[known[v].round], known[v].w);
            end
`ifdef SHA256_SCHED_WK_EN
            check($sformatf("%s_wk0_abc", tag), got_wk[0], 32'hA3EC9318);
`endif
        end
    endtask

    initial begin
        known[0] = '{0,  32'h61626380};
        known[1] = '{1,  32'h00000000};
        known[2] = '{14, 32'h00000000};
        known[3] = '{15, 32'h00000018};
        known[4] = '{16, 32'h61626380};
        known[5] = '{17, 32'h000F0000};
        known[6] = '{18, 32'h7DA86405};
        known[7] = '{19, 32'h600003C6};

        for (int i = 0; i < 16; i++) begin
            abc[i]  = 32'h0;
            ramp[i] = 32'h9E3779B9 * 32'(i + 1);
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        rst_n   = 1'b1;
        clr     = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'h0;
        m_ready = 1'b0;
        #2 rst_n = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_sready", 32'(s_ready), 32'd0);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        check("rst_mdata", m_data, 32'd0);
        check("rst_mround", 32'(m_round), 32'd0);
        check("rst_mlast", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef SHA256_SCHED_WK_EN
        check("rst_mwk", m_wk, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_sready", 32'(s_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // "abc" block, free-flowing consumer.
        build_model(abc);
        send_block(abc, 16, 0);
        collect(1'b0, 1'b0);
        verify("abc", 1'b1);

        // "abc" block, random back-pressure, junk on the input during EMIT.
        send_block(abc, 16, 0);
        collect(1'b1, 1'b1);
        verify("abc_bp", 1'b1);

        // Ramp block with 3-cycle input gaps.
        build_model(ramp);
        send_block(ramp, 16, 3);
        collect(1'b0, 1'b0);
        verify("ramp_gap", 1'b0);

        // Abort at round 20, then a fresh "abc" block.
        build_model(abc);
        send_block(abc, 16, 0);
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 200 && !hit; c++) begin
                m_ready = 1'b1;
                @(negedge clk);
                if (m_valid && m_round == 6'd20) begin
                    hit = 1'b1;
                    clr = 1'b1;
                end
                @(posedge clk); #1;
                clr = 1'b0;
            end
            if (!hit) timeout("reach_round20");
            m_ready = 1'b0;
            check("clr_mvalid", 32'(m_valid), 32'd0);
            check("clr_mround", 32'(m_round), 32'd0);
            check("clr_busy", 32'(busy), 32'd0);
            check("clr_sready", 32'(s_ready), 32'd1);
        end
        send_block(abc, 16, 0);
        collect(1'b0, 1'b0);
        verify("abc_after_clr", 1'b1);

        // Asynchronous reset mid-LOAD after 7 words.
        send_block(ramp, 7, 0);
        check("midload_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_sready", 32'(s_ready), 32'd0);
        check("arst_mvalid", 32'(m_valid), 32'd0);
        check("arst_mdata", m_data, 32'd0);
        check("arst_mround", 32'(m_round), 32'd0);
        check("arst_mlast", 32'(m_last), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_rel_sready", 32'(s_ready), 32'd1);
        build_model(ramp);
        send_block(ramp, 16, 0);
        collect(1'b1, 1'b0);
        verify("ramp_after_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Produces the SHA-256 message schedule W[0..63] from one 512-bit block.
- Input is a stream of 16 big-endian 32-bit words; output is a stream of one W[t] per round.
- Sits between the block loader/padder and the round/compression datapath, which consumes W[t] next to the EP1/EP0/CH/MAJ logic.

Parameters:
- WORD_W, 32, word width; fixed by SHA-256 and checked by an elaboration assertion.
- NWORDS, 16, words per input block and depth of the schedule window.
- ROUNDS, 64, number of W words emitted per block.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort; highest priority after reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  scheduler accepts an input word.
- s_data  in  32  message word; M[0] arrives first.
- m_valid  out  1  W[t] valid.
- m_ready  in  1  round datapath accepts W[t].
- m_data  out  32  W[t].
- m_round  out  6  t, the round index of m_data.
- m_last  out  1  high with t==63.
- busy  out  1  high in LOAD (after the first word) and in EMIT.

Behaviour:
- Reset values (rst_n low, asynchronous): state=IDLE, window words all 0, load count=0, t=0, s_ready=0, m_valid=0, m_data=0, m_round=0, m_last=0, busy=0.
- State IDLE:
  - s_ready=1 the cycle after reset releases.
  - s_valid&&s_ready stores the word into win[0], sets count=1, moves to LOAD.
- State LOAD:
  - s_ready=1, m_valid=0.
  - Each accepted word is written to win[count]; count increments.
  - On the accept with count==15 (16th word): state=EMIT, t=0, s_ready drops the next cycle.
  - Input stalls (s_valid low) hold all state.
- State EMIT:
  - s_ready=0, m_valid=1.
  - m_data=win[0], m_round=t, m_last=(t==63).
  - First m_valid is asserted the cycle after the 16th input accept (1-cycle latency).
  - On m_valid&&m_ready: win[i]<=win[i+1] for i=0..14, and win[15]<=s1(win[14])+win[9]+s0(win[1])+win[0] mod 2^32; t<=t+1.
    - The appended word is W[t+16]; values appended after t>=48 are don't-care and are not visible to the consumer.
  - s0(x)=ROTR7^ROTR18^SHR3; s1(x)=ROTR17^ROTR19^SHR10; all additions wrap at 32 bits with no carry out.
  - Back-pressure (m_ready low): m_data, m_round and window hold stable; AXI-style rule, m_valid never drops without a handshake.
  - Handshake with t==63: state=IDLE, m_valid=0 the next cycle, s_ready=1 the next cycle, window not cleared.
- clr:
  - Any state -> IDLE next cycle; count=0, t=0, m_valid=0.
  - Window contents don't-care.
  - An input or output handshake in the same cycle as clr is discarded.
- Simultaneous s_valid and an EMIT cycle: input is ignored (s_ready=0); no overlap of blocks.

Optional Feature:
- SHA256_SCHED_WK_EN defined:
  - Adds output port m_wk [31:0] = W[t]+K[t] mod 2^32, registered alongside m_data and valid under the same handshake.
  - Reset value 0.
  - K[t] comes from the package constant table, indexed by the t register.
- Undefined: no m_wk port and no K table instantiated.

Decomposition:
- Package sha256_pkg:
  - WORD_W, NWORDS, ROUNDS localparams.
  - state enum {IDLE, LOAD, EMIT}.
  - word_t typedef (logic [31:0]).
  - K[0:63] constant array.
- Sub-module sha256_small_sigma, parameter SEL (0 -> s0, 1 -> s1); combinational; two instances.

Test Plan:
- "abc" padded block (0x61626380, 14×0x00000000, 0x00000018) with m_ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; m_last only at m_round=63; 64 beats total.
- Same block with m_ready toggled by a random 50% pattern -> identical W sequence; m_data and m_round stable whenever m_valid&&!m_ready.
- Input gaps (s_valid low 3 cycles between words) -> s_ready stays 1; first m_valid exactly 1 cycle after the 16th accept.
- clr asserted at m_round=20 -> m_valid=0 next cycle; a fresh "abc" block then yields W0=0x61626380.
- rst_n pulsed low asynchronously mid-LOAD (after 7 words) -> all outputs 0 immediately; the next full block is processed correctly.
- With SHA256_SCHED_WK_EN on the "abc" block -> m_wk at t=0 is 0xA3EC9318 (0x61626380+0x428A2F98).
